// File: rtl/vram_dualport_responder.sv
// Memory end of the VDP video RAM bus: two 64Kx4 dual-port DRAMs seen as one
// 64K x 8 array with a random-access port and a row-wide serial port.
module vram_dualport_responder #(
    parameter int unsigned AW      = 16,
    parameter int unsigned SER_LEN = 256
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic [7:0] AD_i,
    input  logic [7:0] RD_i,
    output logic [7:0] RD_o,
    output logic       RD_d,
    input  logic       RAS1,
    input  logic       CAS1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic       OE1,
    input  logic       SC,
    input  logic       SE0,
    input  logic       SE1,
    output logic [7:0] SD_o,
    output logic [1:0] SD_d
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = (SER_LEN > 1) ? $clog2(SER_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        ACCESS,
        XFER,
        REFRESH
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    ser [SER_LEN];
    logic [7:0]    row, col;
    logic          xfer;
    logic [PW-1:0] ptr, ptr_inc;

    logic ras_q, cas_q, we0_q, we1_q, sc_q;
    logic ras_fall, ras_rise, cas_fall, we0_fall, we1_fall, sc_rise;

    logic          acc, wr_lo, wr_hi, xfer_go, row_ld, col_ld;
    logic          rd_cond;
    logic [7:0]    acc_col;
    logic [AW-1:0] acc_addr;

    assign ras_fall = ras_q & ~RAS1;
    assign ras_rise = ~ras_q & RAS1;
    assign cas_fall = cas_q & ~CAS1;
    assign we0_fall = we0_q & ~WE0;
    assign we1_fall = we1_q & ~WE1;
    assign sc_rise  = ~sc_q & SC;

    // The access cycle at the CAS fall uses the column on the bus, not the latch.
    assign acc_col  = (state == ROW) ? AD_i : col;
    assign acc_addr = AW'({row, acc_col});
    assign rd_cond  = ~OE1 & WE0 & WE1;
    assign ptr_inc  = (ptr == PW'(SER_LEN - 1)) ? '0 : ptr + PW'(1);

    always_ff @(posedge MCLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        acc      = 1'b0;
        wr_lo    = 1'b0;
        wr_hi    = 1'b0;
        xfer_go  = 1'b0;
        row_ld   = 1'b0;
        col_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (ras_fall) begin
                    if (!CAS1) begin
                        state_nx = REFRESH;
                    end else begin
                        row_ld   = 1'b1;
                        state_nx = ROW;
                    end
                end
            end
            ROW: begin
                if (cas_fall) begin
                    col_ld = 1'b1;
                    if (xfer) begin
                        xfer_go  = 1'b1;
                        state_nx = XFER;
                    end else begin
                        acc      = 1'b1;
                        wr_lo    = ~WE0;
                        wr_hi    = ~WE1;
                        state_nx = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (CAS1) begin
                    state_nx = ROW;
                end else begin
                    acc   = 1'b1;
                    wr_lo = we0_fall;
                    wr_hi = we1_fall;
                end
            end
            XFER:    state_nx = XFER;
            REFRESH: state_nx = REFRESH;
            default: state_nx = IDLE;
        endcase
        // Closing the row aborts whatever access was in flight.
        if (ras_rise) begin
            state_nx = IDLE;
            acc      = 1'b0;
            wr_lo    = 1'b0;
            wr_hi    = 1'b0;
            xfer_go  = 1'b0;
            row_ld   = 1'b0;
            col_ld   = 1'b0;
        end
    end

    // Array and serial register survive reset; a write in the reset cycle is dropped.
    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            if (wr_lo) mem[acc_addr][3:0] <= RD_i[3:0];
            if (wr_hi) mem[acc_addr][7:4] <= RD_i[7:4];
            if (xfer_go) begin
                for (int unsigned i = 0; i < SER_LEN; i++) begin
                    ser[i] <= mem[AW'({row, 8'(i)})];
                end
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            ras_q <= 1'b1;
            cas_q <= 1'b1;
            we0_q <= 1'b1;
            we1_q <= 1'b1;
            sc_q  <= 1'b1;
            row   <= '0;
            col   <= '0;
            xfer  <= 1'b0;
            RD_o  <= '0;
            RD_d  <= 1'b1;
            SD_o  <= '0;
            SD_d  <= 2'b11;
            ptr   <= '0;
        end else begin
            ras_q <= RAS1;
            cas_q <= CAS1;
            we0_q <= WE0;
            we1_q <= WE1;
            sc_q  <= SC;
            if (row_ld) begin
                row  <= AD_i;
                xfer <= ~OE1;
            end
            if (col_ld) col <= AD_i;

            // A write in the same cycle as a read condition keeps the bus released.
            RD_d <= 1'b1;
            if (acc && !(wr_lo || wr_hi) && rd_cond) begin
                RD_d <= 1'b0;
                RD_o <= mem[acc_addr];
            end

            SD_d <= {SE1, SE0};
            if (xfer_go) begin
                ptr  <= PW'(AD_i);
                SD_o <= mem[AW'({row, AD_i})];
            end else if (sc_rise) begin
                ptr  <= ptr_inc;
                SD_o <= ser[ptr_inc];
            end
        end
    end

endmodule

// File: tb/tb_vram_dualport_responder.sv
// Directed bench for vram_dualport_responder: transaction-level memory/serial
// model compared against the DUT every cycle, plus literal spot checks.
module tb_vram_dualport_responder;

    logic       MCLK = 1'b0;
    logic       RESET;
    logic [7:0] AD_i, RD_i, RD_o, SD_o;
    logic       RD_d, RAS1, CAS1, WE0, WE1, OE1, SC, SE0, SE1;
    logic [1:0] SD_d;

    vram_dualport_responder dut (
        .MCLK(MCLK), .RESET(RESET), .AD_i(AD_i), .RD_i(RD_i), .RD_o(RD_o),
        .RD_d(RD_d), .RAS1(RAS1), .CAS1(CAS1), .WE0(WE0), .WE1(WE1), .OE1(OE1),
        .SC(SC), .SE0(SE0), .SE1(SE1), .SD_o(SD_o), .SD_d(SD_d)
    );

    always #5 MCLK = ~MCLK;

    // Model state: byte array, serial snapshot, pointer and expected outputs.
    logic [7:0]  m [65536];
    logic [7:0]  ser_m [256];
    int unsigned ptr_m;
    logic [7:0]  cur_row;
    logic [7:0]  exp_rd_o, exp_sd_o;
    logic        exp_rd_d;
    logic [1:0]  exp_sd_d;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge MCLK) begin
        if (chk_en) begin
            check("rd_d", {7'b0, RD_d}, {7'b0, exp_rd_d});
            check("rd_o", RD_o, exp_rd_o);
            check("sd_o", SD_o, exp_sd_o);
            check("sd_d", {6'b0, SD_d}, {6'b0, exp_sd_d});
        end
    end

    // One MCLK; afterwards the expectations describe the edge just taken.
    task automatic step();
        @(posedge MCLK);
        #1;
        if (RESET) begin
            exp_rd_d = 1'b1;
            exp_rd_o = 8'h00;
            exp_sd_o = 8'h00;
            exp_sd_d = 2'b11;
            ptr_m    = 0;
        end else begin
            exp_rd_d = 1'b1;
            exp_sd_d = {SE1, SE0};
        end
    endtask

    task automatic ras_open(input logic [7:0] r, input bit dt);
        AD_i = r; OE1 = dt ? 1'b0 : 1'b1; RAS1 = 1'b0; cur_row = r;
        step();
        OE1 = 1'b1;
    endtask

    task automatic ras_close();
        RAS1 = 1'b1; CAS1 = 1'b1; WE0 = 1'b1; WE1 = 1'b1; OE1 = 1'b1;
        step();
    endtask

    task automatic cas_write(input logic [7:0] c, input logic [7:0] d);
        AD_i = c; RD_i = d; WE0 = 1'b0; WE1 = 1'b0; CAS1 = 1'b0;
        step();
        m[{cur_row, c}] = d;
        WE0 = 1'b1; WE1 = 1'b1; CAS1 = 1'b1;
        step();
    endtask

    task automatic cas_read(input logic [7:0] c, input logic [7:0] lit, input string name);
        AD_i = c; OE1 = 1'b0; CAS1 = 1'b0;
        step();
        exp_rd_d = 1'b0; exp_rd_o = m[{cur_row, c}];
        @(negedge MCLK);
        check(name, RD_o, lit);
        check({name, "_dir"}, {7'b0, RD_d}, 8'h00);
        step();
        exp_rd_d = 1'b0; exp_rd_o = m[{cur_row, c}];
        CAS1 = 1'b1; OE1 = 1'b1;
        step();
    endtask

    task automatic sc_pulse(input logic [7:0] lit, input string name);
        SC = 1'b1;
        step();
        ptr_m = (ptr_m + 1) % 256;
        exp_sd_o = ser_m[ptr_m];
        @(negedge MCLK);
        check(name, SD_o, lit);
        SC = 1'b0;
        step();
    endtask

    task automatic transfer(input logic [7:0] r, input logic [7:0] c, input bit with_sc,
                            input logic [7:0] lit, input string name);
        ras_open(r, 1'b1);
        AD_i = c; CAS1 = 1'b0;
        if (with_sc) SC = 1'b1;
        step();
        for (int i = 0; i < 256; i++) ser_m[i] = m[{r, 8'(i)}];
        ptr_m = c;
        exp_sd_o = ser_m[c];
        @(negedge MCLK);
        check(name, SD_o, lit);
        SC = 1'b0; CAS1 = 1'b1;
        step();
        RAS1 = 1'b1;
        step();
    endtask

    initial begin
        RESET = 1'b1; AD_i = '0; RD_i = '0; RAS1 = 1'b1; CAS1 = 1'b1;
        WE0 = 1'b1; WE1 = 1'b1; OE1 = 1'b1; SC = 1'b0; SE0 = 1'b1; SE1 = 1'b1;
        cur_row = '0; ptr_m = 0;
        step();
        chk_en = 1'b1;
        step();
        @(negedge MCLK);
        check("reset_rd_d", {7'b0, RD_d}, 8'h01);
        check("reset_sd_d", {6'b0, SD_d}, 8'h03);
        check("reset_rd_o", RD_o, 8'h00);
        check("reset_sd_o", SD_o, 8'h00);
        RESET = 1'b0;
        step();

        // Early write, then a separate read cycle.
        ras_open(8'h12, 1'b0); cas_write(8'h34, 8'hA5); ras_close();
        ras_open(8'h12, 1'b0); cas_read(8'h34, 8'hA5, "early_rd"); ras_close();

        // Late write of the upper nibble only.
        ras_open(8'h12, 1'b0);
        AD_i = 8'h34; CAS1 = 1'b0;
        step();
        RD_i = 8'h3C; WE1 = 1'b0;
        step();
        m[16'h1234][7:4] = 4'h3;
        WE1 = 1'b1; CAS1 = 1'b1;
        step();
        ras_close();
        ras_open(8'h12, 1'b0); cas_read(8'h34, 8'h35, "late_rd"); ras_close();

        // Page mode writes then reads in one row.
        ras_open(8'h00, 1'b0);
        cas_write(8'h01, 8'h11); cas_write(8'h02, 8'h22); cas_write(8'h03, 8'h33);
        ras_close();
        ras_open(8'h00, 1'b0);
        cas_read(8'h01, 8'h11, "page_rd1");
        cas_read(8'h02, 8'h22, "page_rd2");
        cas_read(8'h03, 8'h33, "page_rd3");
        ras_close();

        // CAS-before-RAS refresh, including a CAS fall inside it.
        AD_i = 8'h00; CAS1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0; RD_i = 8'hFF;
        step();
        RAS1 = 1'b0;
        step();
        AD_i = 8'h03; CAS1 = 1'b1;
        step();
        CAS1 = 1'b0;
        step();
        ras_close();
        // RAS and CAS falling together also mean refresh.
        AD_i = 8'h00; RAS1 = 1'b0; CAS1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        step();
        AD_i = 8'h01; CAS1 = 1'b1;
        step();
        CAS1 = 1'b0;
        step();
        ras_close();
        ras_open(8'h00, 1'b0);
        cas_read(8'h03, 8'h33, "refresh_rd3");
        cas_read(8'h01, 8'h11, "refresh_rd1");
        ras_close();

        // Transfer and serial readout with wrap.
        ras_open(8'h05, 1'b0);
        for (int c = 0; c < 256; c++) cas_write(8'(c), 8'(c));
        ras_close();
        SE0 = 1'b0; SE1 = 1'b0;
        transfer(8'h05, 8'hFE, 1'b0, 8'hFE, "xfer_fe");
        sc_pulse(8'hFF, "ser_ff");
        sc_pulse(8'h00, "ser_wrap");
        sc_pulse(8'h01, "ser_01");
        @(negedge MCLK);
        check("ser_dir", {6'b0, SD_d}, 8'h00);
        ras_open(8'h05, 1'b0); cas_write(8'h02, 8'h77); ras_close();
        sc_pulse(8'h02, "ser_isolated");
        // Transfer wins over a simultaneous SC rise; new snapshot sees the write.
        transfer(8'h05, 8'h01, 1'b1, 8'h01, "xfer_sc");
        sc_pulse(8'h77, "ser_resnap");

        // Reset in the middle of a read.
        ras_open(8'h12, 1'b0);
        AD_i = 8'h34; OE1 = 1'b0; CAS1 = 1'b0;
        step();
        exp_rd_d = 1'b0; exp_rd_o = m[16'h1234];
        @(negedge MCLK);
        check("pre_reset_dir", {7'b0, RD_d}, 8'h00);
        RESET = 1'b1;
        step();
        @(negedge MCLK);
        check("midrst_rd_d", {7'b0, RD_d}, 8'h01);
        check("midrst_sd_d", {6'b0, SD_d}, 8'h03);
        RESET = 1'b0; RAS1 = 1'b1; CAS1 = 1'b1; OE1 = 1'b1;
        step();
        sc_pulse(8'h01, "ptr_after_rst");

        // A write in the reset cycle must not land.
        ras_open(8'h12, 1'b0);
        AD_i = 8'h34; RD_i = 8'hEE; WE0 = 1'b0; WE1 = 1'b0; CAS1 = 1'b0; RESET = 1'b1;
        step();
        RESET = 1'b0; RAS1 = 1'b1; CAS1 = 1'b1; WE0 = 1'b1; WE1 = 1'b1;
        step();
        ras_open(8'h12, 1'b0); cas_read(8'h34, 8'h35, "post_rst_rd"); ras_close();

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_dualport_responder.md
Name: vram_dualport_responder

Overview:
- Responder on the video RAM side of the FC1004 VDP memory interface: the memory end of that bus, for the FPGA core and for simulation.
- Behaves as the two 64Kx4 dual-port DRAMs on the board, together forming one 64K x 8 array.
- Random-access port: AD, RD, RAS1, CAS1, WE0, WE1, OE1.
- Serial port: SC, SE0, SE1, SD.
- All strobes are active-low and are sampled and edge-detected on MCLK; there is no asynchronous logic.

Parameters:
- AW, 16, address width. The array has 2^AW bytes; the upper row bits are dropped when AW < 16.
- SER_LEN, 256, serial register length in bytes. It equals one row.

Ports:
- MCLK in 1: system clock. The only clock.
- RESET in 1: synchronous, active-high reset.
- AD_i in 8: multiplexed address, row then column.
- RD_i in 8: write data from the VDP.
- RD_o out 8: read data to the VDP.
- RD_d out 1: RD direction. 1 = input (high-Z), 0 = driving.
- RAS1 in 1: row strobe, active low.
- CAS1 in 1: column strobe, active low.
- WE0 in 1: write enable for nibble RD[3:0], active low.
- WE1 in 1: write enable for nibble RD[7:4], active low.
- OE1 in 1: output enable, active low. Doubles as DT (transfer select) when RAS falls.
- SC in 1: serial clock. Advances on its rising edge.
- SE0 in 1: serial enable for SD[3:0], active low.
- SE1 in 1: serial enable for SD[7:4], active low.
- SD_o out 8: serial data out.
- SD_d out 2: per-nibble direction. Bit 0 covers [3:0], bit 1 covers [7:4]. 1 = high-Z.

Behaviour:
- Edges: each strobe has a previous-value register. A fall is prev=1 and now=0; a rise is prev=0 and now=1. At reset the previous values are set to 1.
- Reset values:
  - state=IDLE, RD_o=0, RD_d=1, SD_o=0, SD_d=2'b11, ptr=0.
  - Row/column latches are 0; the serial register is not cleared.
  - The array contents are preserved; they are never cleared.
- States: IDLE, ROW, ACCESS, XFER, REFRESH.
- IDLE, on RAS fall:
  - If CAS=0, go to REFRESH (CAS-before-RAS). There is no access.
  - Otherwise latch row=AD_i and xfer=~OE1, then go to ROW.
- ROW, on CAS fall:
  - Latch col=AD_i.
  - If xfer=1, go to XFER.
  - Otherwise go to ACCESS and evaluate the access in the same cycle.
- ACCESS, evaluated every cycle while CAS=0:
  - Write: a nibble is written when its WE is 0 at the CAS fall (early write), or when its WE falls while CAS=0 (late write). That nibble of mem[{row,col}] takes RD_i. Each nibble is written independently.
  - Read: when OE1=0 and WE0=WE1=1, RD_d=0 and RD_o=mem[{row,col}], registered. Latency is 1 MCLK after the CAS fall or OE fall.
  - Otherwise RD_d=1 and RD_o holds its last value.
  - Page mode: on CAS rise, RD_d=1 on the next cycle and the state returns to ROW with the row kept. A new CAS fall latches a new column.
- XFER:
  - In one cycle, the serial register snapshots mem[{row, 0..SER_LEN-1}] and ptr=col.
  - SD_o=snapshot[col] on the following cycle.
  - Then wait in XFER until RAS rises. RD_d stays 1 throughout.
- REFRESH: no effect on memory or outputs; wait for RAS rise.
- RAS rise in any state: go to IDLE and set RD_d=1 on the next cycle. This applies mid-write, mid-read and mid-page.
- Serial port:
  - On an SC rise, ptr=(ptr+1) mod SER_LEN and SD_o=ser[new ptr], registered, so the result appears 1 cycle after the SC rise.
  - The pointer wraps 255→0.
  - SD_d[0]=SE0 and SD_d[1]=SE1, registered. A nibble whose enable is off still advances the pointer.
- Snapshot isolation: writes to the array after a transfer do not change the serial register until the next transfer.
- Simultaneous events:
  - Transfer and an SC rise in the same cycle: the transfer wins, ptr=col, and that SC edge is discarded.
  - RAS and CAS falling in the same cycle from IDLE: this counts as CAS=0 at the RAS fall, so it is a refresh.
  - Write and read conditions both true: the write wins and RD_d=1.
- RESET asserted mid-cycle: the next cycle is the reset state. An in-progress write of the current cycle is not committed.

Test Plan:
- Early write then read:
  - Stimulus: RAS fall with AD=0x12, CAS fall with AD=0x34 and WE0=WE1=0, RD_i=0xA5. Next cycle, RAS fall 0x12, CAS fall 0x34, OE1=0.
  - Required: RD_d=0 and RD_o=0xA5, one MCLK after the CAS fall.
- Nibble and late write:
  - Stimulus: mem[0x1234]=0xA5. CAS fall with WE high, then WE1 falls with RD_i=0x3C.
  - Required: a read gives 0x35.
- Page mode:
  - Stimulus: row 0x00. CAS cycles with columns 0x01, 0x02, 0x03, writing 0x11, 0x22, 0x33. Then page-read the same columns.
  - Required: 0x11, 0x22, 0x33 in order, with RD_d=1 between CAS pulses.
- Refresh:
  - Stimulus: CAS=0 before the RAS fall, WE0=0.
  - Required: no memory change and RD_d stays 1.
- Transfer and serial:
  - Stimulus: fill row 0x05 with data equal to the column index. Transfer with OE1=0 at the RAS fall and col=0xFE. Apply 3 SC rises with SE0=SE1=0.
  - Required: SD_o sequence 0xFE, 0xFF, 0x00, 0x01 (wrap), SD_d=2'b00.
  - Follow-up: write mem[0x0502]=0x77.
  - Required: the serial output is still 0x02 at ptr 2.
- Reset mid-read:
  - Stimulus: RESET=1 while RD_d=0.
  - Required: next cycle RD_d=1, SD_d=2'b11, ptr=0, and a subsequent read returns the pre-reset memory contents.
